// File: rtl/nvdla_sync_fifo_wm_if.sv
// Producer/consumer handshake bundle for nvdla_sync_fifo_wm.
// master = the side that pushes and pops; slave = the FIFO itself.
interface nvdla_sync_fifo_wm_if #(
  parameter int DW = 6
);
  logic          wr_req;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_req;
  logic          rd_ready;
  logic [DW-1:0] rd_data;

  modport master (
    output wr_req, wr_data, rd_ready,
    input  wr_ready, rd_req, rd_data
  );

  modport slave (
    input  wr_req, wr_data, rd_ready,
    output wr_ready, rd_req, rd_data
  );
endinterface

// File: rtl/nvdla_sync_fifo_wm.sv
// Single-clock FIFO with runtime limit, watermark and flush; 2-cycle push-to-rd_req latency.
// wr_ready is registered from next occupancy; the output register holds while rd_ready is low.
module nvdla_sync_fifo_wm #(
  parameter  int DW    = 6,
  parameter  int DEPTH = 128,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic                clk,
  input  logic                reset_,
  nvdla_sync_fifo_wm_if.slave io,
  input  logic                flush,
  input  logic [CW-1:0]       wr_limit,
  input  logic [CW-1:0]       afull_thresh,
  output logic                afull,
  output logic [CW-1:0]       wr_count,
  output logic                idle,
  input  logic [31:0]         pwrbus_ram_pd
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_dout_q;

  logic [AW-1:0] wr_adr_q, wr_adr_d;
  logic [AW-1:0] rd_adr_q, rd_adr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] ram_cnt_q, ram_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          out_vld_q, out_vld_d;
  logic [DW-1:0] out_dat_q, out_dat_d;
  logic          wr_ready_q, wr_ready_d;
  logic          afull_q, afull_d;

  logic [CW-1:0] lim;
  logic          push, pop, out_free, out_load, rd_issue;

  // The behavioural array models the RAM macro, which has no power pins here.
  logic unused_pwrbus;
  assign unused_pwrbus = ^pwrbus_ram_pd;

  always_comb begin
    lim      = (wr_limit == '0 || wr_limit > DEPTH_C) ? DEPTH_C : wr_limit;
    push     = io.wr_req && wr_ready_q && !flush;
    pop      = out_vld_q && io.rd_ready && !flush;
    out_free = !out_vld_q || pop;
    out_load = rd_pend_q && out_free;
    // ram_cnt_q only counts words written at an earlier edge, so a read
    // never targets the address being written in the same cycle.
    rd_issue = (ram_cnt_q != '0) && (!rd_pend_q || out_free) && !flush;

    wr_adr_d  = wr_adr_q + AW'(push);
    rd_adr_d  = rd_adr_q + AW'(rd_issue);
    count_d   = count_q + CW'(push) - CW'(pop);
    ram_cnt_d = ram_cnt_q + CW'(push) - CW'(rd_issue);

    rd_pend_d = rd_pend_q;
    if (out_load) rd_pend_d = 1'b0;
    if (rd_issue) rd_pend_d = 1'b1;

    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    if (pop) out_vld_d = 1'b0;
    if (out_load) begin
      out_vld_d = 1'b1;
      out_dat_d = ram_dout_q;
    end

    if (flush) begin
      wr_adr_d  = '0;
      rd_adr_d  = '0;
      count_d   = '0;
      ram_cnt_d = '0;
      rd_pend_d = 1'b0;
      out_vld_d = 1'b0;
    end

    wr_ready_d = count_d < lim;
    afull_d    = (afull_thresh != '0) && (count_d >= afull_thresh);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_adr_q   <= '0;
      rd_adr_q   <= '0;
      count_q    <= '0;
      ram_cnt_q  <= '0;
      rd_pend_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      wr_ready_q <= 1'b1;
      afull_q    <= 1'b0;
    end else begin
      wr_adr_q   <= wr_adr_d;
      rd_adr_q   <= rd_adr_d;
      count_q    <= count_d;
      ram_cnt_q  <= ram_cnt_d;
      rd_pend_q  <= rd_pend_d;
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      wr_ready_q <= wr_ready_d;
      afull_q    <= afull_d;
    end
  end

  // RAM: one write port, one registered read port; dout holds between reads.
  always_ff @(posedge clk) begin
    if (push)     mem[wr_adr_q] <= io.wr_data;
    if (rd_issue) ram_dout_q    <= mem[rd_adr_q];
  end

  assign io.wr_ready = wr_ready_q;
  assign io.rd_req   = out_vld_q;
  assign io.rd_data  = out_dat_q;
  assign afull       = afull_q;
  assign wr_count    = count_q;
  assign idle        = (count_q == '0) && !rd_pend_q;

endmodule

// File: tb/tb_nvdla_sync_fifo_wm.sv
// Directed bench for nvdla_sync_fifo_wm (DEPTH=128, DW=16).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_nvdla_sync_fifo_wm;
  localparam int DW    = 16;
  localparam int DEPTH = 128;
  localparam int CW    = 8;

  logic          clk;
  logic          reset_;
  logic          flush;
  logic [CW-1:0] wr_limit;
  logic [CW-1:0] afull_thresh;
  logic          afull;
  logic [CW-1:0] wr_count;
  logic          idle;
  logic [31:0]   pwrbus_ram_pd;

  int total = 0;
  int bad   = 0;

  nvdla_sync_fifo_wm_if #(.DW(DW)) bus ();

  nvdla_sync_fifo_wm #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset_        (reset_),
    .io            (bus),
    .flush         (flush),
    .wr_limit      (wr_limit),
    .afull_thresh  (afull_thresh),
    .afull         (afull),
    .wr_count      (wr_count),
    .idle          (idle),
    .pwrbus_ram_pd (pwrbus_ram_pd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_wr_ready", bus.wr_ready, 1);
    chk("rst_rd_req",   bus.rd_req,   0);
    chk("rst_rd_data",  bus.rd_data,  0);
    chk("rst_afull",    afull,        0);
    chk("rst_wr_count", wr_count,     0);
    chk("rst_idle",     idle,         1);
  endtask

  task automatic single_word();
    bus.wr_req = 1'b1; bus.wr_data = 16'h002A;
    tick();
    bus.wr_req = 1'b0;
    chk("sw_count_e0", wr_count,   1);
    chk("sw_rdreq_e0", bus.rd_req, 0);
    tick();
    chk("sw_rdreq_e1", bus.rd_req, 0);
    tick();
    chk("sw_rdreq_e2", bus.rd_req,  1);
    chk("sw_data_e2",  bus.rd_data, 32'h2A);
    chk("sw_idle_e2",  idle,        0);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    chk("sw_count_pop", wr_count,   0);
    chk("sw_rdreq_pop", bus.rd_req, 0);
    chk("sw_idle_pop",  idle,       1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  int  acc, sent, rcv, maxc;
  logic pushed, popped;

  initial begin
    reset_ = 1'b0; flush = 1'b0; wr_limit = '0; afull_thresh = '0;
    pwrbus_ram_pd = '0;
    bus.wr_req = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
    tick();
    tick();
    chk_reset_vals();
    reset_ = 1'b1;
    tick();

    single_word();

    // Fill to DEPTH with the consumer stalled.
    acc = 0;
    bus.wr_req = 1'b1;
    for (int i = 0; i < 140; i++) begin
      bus.wr_data = 16'(acc);
      pushed = bus.wr_ready;
      tick();
      if (pushed) acc++;
    end
    bus.wr_req = 1'b0;
    chk("fill_accepts",  acc,          128);
    chk("fill_wr_ready", bus.wr_ready, 0);
    chk("fill_count",    wr_count,     128);
    chk("fill_afull",    afull,        0);
    chk("fill_head",     bus.rd_data,  0);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    chk("fill_pop_ready", bus.wr_ready, 1);
    chk("fill_pop_count", wr_count,     127);
    chk("fill_pop_next",  bus.rd_data,  1);
    do_flush();
    chk("fill_flushed", wr_count, 0);

    // Soft limit 10, watermark 8.
    wr_limit = 8'd10; afull_thresh = 8'd8;
    bus.wr_req = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      bus.wr_data = 16'(100 + i);
      tick();
      if (i == 7)  chk("lim_afull7",  afull, 0);
      if (i == 8)  chk("lim_afull8",  afull, 1);
      if (i == 8)  chk("lim_count8",  wr_count, 8);
      if (i == 9)  chk("lim_ready9",  bus.wr_ready, 1);
      if (i == 10) chk("lim_ready10", bus.wr_ready, 0);
      if (i == 12) chk("lim_count12", wr_count, 10);
    end
    bus.wr_req = 1'b0;
    wr_limit = 8'd5;
    tick();
    chk("lim5_ready", bus.wr_ready, 0);
    bus.rd_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("lim5_rdreq", bus.rd_req,  1);
      chk("lim5_data",  bus.rd_data, 32'(101 + k));
      tick();
      chk("lim5_ready_pop", bus.wr_ready, (k == 5) ? 1 : 0);
    end
    bus.rd_ready = 1'b0;
    chk("lim5_count", wr_count, 4);
    chk("lim5_afull", afull,    0);
    do_flush();
    wr_limit = '0; afull_thresh = '0;
    tick();

    // 300 incrementing words with a randomly stalling consumer.
    sent = 0; rcv = 0; maxc = 0;
    for (int cyc = 0; cyc < 3000 && rcv < 300; cyc++) begin
      bus.rd_ready = 1'($urandom_range(0, 1));
      bus.wr_req   = (sent < 300);
      bus.wr_data  = 16'(sent);
      pushed = bus.wr_req && bus.wr_ready;
      popped = bus.rd_req && bus.rd_ready;
      if (popped) chk("stream_data", bus.rd_data, 32'(rcv));
      tick();
      if (pushed) sent++;
      if (popped) rcv++;
      chk("stream_count", wr_count, 32'(sent - rcv));
      if (int'(wr_count) > maxc) maxc = int'(wr_count);
    end
    bus.wr_req = 1'b0; bus.rd_ready = 1'b0;
    chk("stream_received", rcv, 300);
    chk("stream_max_le_depth", (maxc <= DEPTH) ? 1 : 0, 1);
    chk("stream_idle", idle, 1);

    // Flush with 20 queued and a concurrent push/pop request.
    bus.wr_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.wr_data = 16'(200 + i);
      tick();
    end
    chk("fl_count_pre", wr_count, 20);
    bus.rd_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0; bus.wr_req = 1'b0; bus.rd_ready = 1'b0;
    chk("fl_rd_req",   bus.rd_req,   0);
    chk("fl_count",    wr_count,     0);
    chk("fl_wr_ready", bus.wr_ready, 1);
    chk("fl_idle",     idle,         1);
    chk("fl_afull",    afull,        0);
    bus.wr_req = 1'b1; bus.wr_data = 16'h0015;
    tick();
    bus.wr_req = 1'b0;
    tick();
    chk("fl_post_rdreq1", bus.rd_req, 0);
    tick();
    chk("fl_post_rdreq2", bus.rd_req,  1);
    chk("fl_post_data",   bus.rd_data, 32'h15);
    chk("fl_post_count",  wr_count,    1);
    do_flush();

    // Reset mid-stream with 50 queued, limited and above the watermark.
    wr_limit = 8'd50; afull_thresh = 8'd40;
    bus.wr_req = 1'b1;
    for (int i = 0; i < 55; i++) begin
      bus.wr_data = 16'(300 + i);
      tick();
    end
    bus.wr_req = 1'b0;
    chk("mr_count",    wr_count,     50);
    chk("mr_wr_ready", bus.wr_ready, 0);
    chk("mr_afull",    afull,        1);
    chk("mr_rd_req",   bus.rd_req,   1);
    reset_ = 1'b0;
    #1;
    chk_reset_vals();
    wr_limit = '0; afull_thresh = '0;
    tick();
    tick();
    reset_ = 1'b1;
    tick();
    single_word();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nvdla_sync_fifo_wm.md
# nvdla_sync_fifo_wm

Parametrised single-clock FIFO for CDMA/CDP datapaths. It generalises the fixed 128x6 direct-convolution FIFO to any power-of-two depth and any data width. On top of that it adds a runtime write limit, an almost-full watermark, an occupancy output, a synchronous flush and an idle indicator. The block sits between a producer with valid/ready handshake and a consumer that may stall; storage is one `nv_ram_rwsp`-class RAM with 1-cycle read, plus an output register.

## Interface
- DW, 6, data width in bits (>=1)
- DEPTH, 128, total entry capacity; power of two, 4..1024
- AW, log2(DEPTH), derived; RAM address width
- CW, AW+1, derived; count/limit width (holds 0..DEPTH)

Ports:
- clk  in  1  clock
- reset_  in  1  reset; asynchronous, active-low
- wr_req  in  1  write valid
- wr_ready  out  1  write ready (registered)
- wr_data  in  DW  write data, sampled when wr_req && wr_ready
- rd_req  out  1  read valid (registered)
- rd_ready  in  1  consumer ready
- rd_data  out  DW  read data (registered); stable while rd_req && !rd_ready
- flush  in  1  synchronous clear
- wr_limit  in  CW  soft capacity; 0 or >DEPTH means DEPTH
- afull_thresh  in  CW  almost-full threshold; 0 disables
- afull  out  1  count >= afull_thresh (registered)
- wr_count  out  CW  occupancy (registered)
- idle  out  1  count==0 and no read in flight
- pwrbus_ram_pd  in  32  RAM power-down bus, passed to RAM

## Operation
- Push: wr_req && wr_ready at a rising edge. Data is written to RAM[wr_adr] and wr_adr increments mod DEPTH.
- Pop: rd_req && rd_ready at a rising edge.
- Occupancy:
  - count = accepted words not yet popped; includes words in the RAM, in the read pipe and in the output register.
  - count_next = count + push - pop.
- Effective limit: L = (wr_limit==0 || wr_limit>DEPTH) ? DEPTH : wr_limit.
- wr_ready register takes (count_next < L) every edge. Consequently:
  - Lowering wr_limit below count deasserts wr_ready next cycle; no data is dropped.
  - Raising wr_limit reasserts wr_ready next cycle.
- afull register takes (afull_thresh!=0 && count_next >= afull_thresh). wr_count register takes count_next.
- Read pipe:
  - A RAM read is issued whenever a word is in the RAM and not yet fetched, and the output register is empty, popping, or about to be freed.
  - At most one word is held in the RAM output stage. rd_adr increments on each issued read.
  - The output register loads RAM dout one cycle after the read is issued.
  - rd_req/rd_data change only when the output register is empty or popped.
- Same-cycle push to an empty FIFO: the RAM read is not issued until the cycle after the write. This avoids write/read contention on one address.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full (count==L): wr_ready=0, so no push is possible. A pop in that cycle gives wr_ready=1 on the next cycle.
- Wrap-around: pointers roll over from DEPTH-1 to 0 with no gap; count never exceeds DEPTH.
- flush=1 at an edge:
  - Pointers are set to 0, count to 0, read pipe emptied, rd_req=0, wr_ready=1, afull=0.
  - wr_req and rd_ready in that cycle are ignored; no push or pop is counted.
- idle = (count==0) && no RAM read in flight; it is combinational from registers.
- Reset values: wr_ready=1, rd_req=0, rd_data=0, afull=0, wr_count=0, idle=1; pointers 0.

## Timing
- Latency: a word pushed at edge N into an empty FIFO gives rd_req=1 after edge N+2, with rd_data valid.
- Throughput: 1 word/cycle sustained with rd_ready held high.
- Handshake rules:
  - The producer must hold wr_data only during the accept cycle.
  - The block never drops rd_req without a pop or a flush.
- wr_ready, afull and wr_count reflect the state after the previous edge; there are no combinational input-to-output paths.
- Mid-operation reset asynchronously forces the reset values; RAM contents are don't-care.

## Test plan
- Single word: DEPTH=128, push 0x2A at edge 0 into an empty FIFO -> rd_req=1 and rd_data=0x2A after edge 2; wr_count=1 after edge 0 and 0 after the pop edge.
- Fill and backpressure:
  - Stimulus: rd_ready=0, wr_limit=0, push continuously.
  - Required: exactly 128 accepts; wr_ready=0 after the 128th; wr_count=128.
  - Then one pop -> wr_ready=1 next cycle.
- Limit and watermark:
  - Stimulus: wr_limit=10, afull_thresh=8, rd_ready=0.
  - Required: afull=1 after the 8th push; wr_ready=0 after the 10th.
  - Then set wr_limit=5 -> wr_ready stays 0 until count<5.
- Streaming wrap: push 300 incrementing words with rd_ready random 50% -> 300 words read in order with no gap or duplicate across pointer wrap; wr_count never >128.
- Flush: with 20 words queued and a simultaneous wr_req and rd_ready, assert flush -> next cycle rd_req=0, wr_count=0, wr_ready=1, idle=1; a subsequent push of 0x15 appears 2 cycles later.
- Reset mid-stream: assert reset_=0 while rd_req=1 and count=50 -> all outputs go to their reset values immediately; after release, a single-word test passes.
